// File: rtl/mpu_spi_responder.sv
// mpu_spi_responder: SPI mode-3 responder emulating the MPU-9250 register map.
// All SPI pins are oversampled in the i_Clk domain. A 128x8 register file
// serves auto-incrementing burst reads and writes. TEMP_OUT_H/L are frozen
// from a local holding register at every chip-select fall.
module mpu_spi_responder #(
    parameter logic [7:0] WHO_AM_I_VAL   = 8'h71,
    parameter logic [7:0] PWR_MGMT_1_RST = 8'h01
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_cs_n,
    input  logic        i_SPI_Clk,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    output logic        o_miso_oe,
    input  logic [15:0] i_temp_raw,
    input  logic        i_temp_valid,
    output logic        o_wr_valid,
    output logic [6:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_busy
);

    localparam logic [6:0] ADDR_TEMP_H = 7'h41;
    localparam logic [6:0] ADDR_TEMP_L = 7'h42;
    localparam logic [6:0] ADDR_PWR_1  = 7'h6B;
    localparam logic [6:0] ADDR_WHO    = 7'h75;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Registers the master may not overwrite.
    function automatic logic is_read_only(input logic [6:0] addr);
        is_read_only = (addr == ADDR_TEMP_H) || (addr == ADDR_TEMP_L) ||
                       (addr == ADDR_WHO);
    endfunction

    // Power-on content of one register-file entry.
    function automatic logic [7:0] reset_value(input logic [6:0] addr);
        if (addr == ADDR_PWR_1) begin
            reset_value = PWR_MGMT_1_RST;
        end else if (addr == ADDR_WHO) begin
            reset_value = WHO_AM_I_VAL;
        end else begin
            reset_value = 8'h00;
        end
    endfunction

    // Synchronizer stages. They are deliberately left out of reset so that
    // a reset in the middle of a frame (CS_n still low) does not look like
    // a fresh CS_n fall once reset is released.
    logic       r_cs_meta, r_cs_sync, r_cs_d;
    logic       r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic       r_mosi_meta, r_mosi_sync;

    state_t     r_state;
    logic [7:0] r_regs [0:127];
    logic [15:0] r_temp_hold;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [6:0] r_addr;
    logic       r_miso;
    logic       r_miso_oe;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_busy;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_last_bit;
    logic [7:0] w_byte;

    // Bring the asynchronous SPI pins into the i_Clk domain, keep one extra
    // stage of SCLK and CS_n for edge detection.
    always_ff @(posedge i_Clk) begin
        r_cs_meta   <= i_cs_n;
        r_cs_sync   <= r_cs_meta;
        r_cs_d      <= r_cs_sync;
        r_sclk_meta <= i_SPI_Clk;
        r_sclk_sync <= r_sclk_meta;
        r_sclk_d    <= r_sclk_sync;
        r_mosi_meta <= i_SPI_MOSI;
        r_mosi_sync <= r_mosi_meta;
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_d;
    assign w_cs_fall   = r_cs_d & ~r_cs_sync;
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift[6:0], r_mosi_sync};

    // Transaction FSM, register file, temperature holding register and all
    // registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state     <= ST_IDLE;
            r_temp_hold <= 16'h0000;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_addr      <= 7'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'h00;
            r_busy      <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                r_regs[i] <= reset_value(7'(i));
            end
        end else begin
            r_wr_valid <= 1'b0;
            r_miso_oe  <= ~r_cs_sync;
            // Snapshot below reads the old value when both happen together.
            if (i_temp_valid) begin
                r_temp_hold <= i_temp_raw;
            end else begin
                r_temp_hold <= r_temp_hold;
            end

            if ((r_state != ST_IDLE) && r_cs_sync) begin
                // Deselect aborts; any partial byte is simply dropped.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_cs_fall) begin
                            r_state             <= ST_CMD;
                            r_busy              <= 1'b1;
                            r_bit_cnt           <= 3'd0;
                            r_regs[ADDR_TEMP_H] <= r_temp_hold[15:8];
                            r_regs[ADDR_TEMP_L] <= r_temp_hold[7:0];
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        r_miso <= 1'b0;
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (w_byte[7]) begin
                                    // Preload the first read byte right away so
                                    // it is ready before the next SCLK fall.
                                    r_state <= ST_RD;
                                    r_tx    <= r_regs[w_byte[6:0]];
                                    r_addr  <= w_byte[6:0] + 7'd1;
                                end else begin
                                    r_state <= ST_WR;
                                    r_addr  <= w_byte[6:0];
                                end
                            end else begin
                                r_state <= ST_CMD;
                            end
                        end else begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_RD: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end else if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_tx   <= r_regs[r_addr];
                                r_addr <= r_addr + 7'd1;
                            end else begin
                                r_addr <= r_addr;
                            end
                        end else begin
                            r_miso <= r_miso;
                        end
                    end
                    ST_WR: begin
                        r_miso <= 1'b0;
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (!is_read_only(r_addr)) begin
                                    r_regs[r_addr] <= w_byte;
                                    r_wr_valid     <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_wr_data      <= w_byte;
                                end else begin
                                    r_wr_valid <= 1'b0;
                                end
                                r_addr <= r_addr + 7'd1;
                            end else begin
                                r_addr <= r_addr;
                            end
                        end else begin
                            r_addr <= r_addr;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_SPI_MISO = r_miso;
    assign o_miso_oe  = r_miso_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_mpu_spi_responder.sv
// Directed bench for mpu_spi_responder: acts as an SPI mode-3 master with
// SCLK at 1/10 of i_Clk and compares against hand-computed values.
module tb_mpu_spi_responder;

    logic        clk;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int          n_cmp;
    int          n_err;
    int          wr_cnt;
    logic [6:0]  last_wr_addr;
    logic [7:0]  last_wr_data;
    logic [7:0]  rx;
    logic [7:0]  rx2;

    mpu_spi_responder dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_cs_n       (cs_n),
        .i_SPI_Clk    (sclk),
        .i_SPI_MOSI   (mosi),
        .o_SPI_MISO   (miso),
        .o_miso_oe    (miso_oe),
        .i_temp_raw   (temp_raw),
        .i_temp_valid (temp_valid),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted write pulse.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Clock out the top n bits of tx MSB first; MISO captured on each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx_o);
        rx_o = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            #50;
            sclk = 1'b1;
            rx_o[i] = miso;
            #50;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #50;
        cs_n = 1'b1;
        #200;
    endtask

    task automatic temp_pulse(input logic [15:0] val);
        @(negedge clk);
        temp_raw   = val;
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    // Single-register read: command byte then one dummy byte.
    task automatic read1(input logic [7:0] cmd, output logic [7:0] val);
        logic [7:0] junk;
        cs_begin();
        spi_bits(cmd, 8, junk);
        spi_bits(8'h00, 8, val);
        cs_end();
    endtask

    initial begin
        int wr_before;
        n_cmp      = 0;
        n_err      = 0;
        wr_cnt     = 0;
        rst        = 1'b1;
        cs_n       = 1'b1;
        sclk       = 1'b1;
        mosi       = 1'b0;
        temp_raw   = 16'h0000;
        temp_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_miso", {15'd0, miso}, 16'h0000);
        check_val("rst_oe", {15'd0, miso_oe}, 16'h0000);
        check_val("rst_wr_valid", {15'd0, wr_valid}, 16'h0000);
        check_val("rst_wr_addr", {9'd0, wr_addr}, 16'h0000);
        check_val("rst_wr_data", {8'd0, wr_data}, 16'h0000);
        check_val("rst_busy", {15'd0, busy}, 16'h0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // WHO_AM_I, busy/oe during a frame, command-phase MISO
        cs_begin();
        check_val("busy_hi", {15'd0, busy}, 16'h0001);
        check_val("oe_hi", {15'd0, miso_oe}, 16'h0001);
        spi_bits(8'hF5, 8, rx);
        check_val("cmd_miso", {8'd0, rx}, 16'h0000);
        spi_bits(8'h00, 8, rx);
        check_val("who_am_i", {8'd0, rx}, 16'h0071);
        cs_end();
        check_val("busy_lo", {15'd0, busy}, 16'h0000);
        check_val("oe_lo", {15'd0, miso_oe}, 16'h0000);
        read1(8'hEB, rx);
        check_val("pwr_rst", {8'd0, rx}, 16'h0001);
        check_val("no_wr_on_read", wr_cnt[15:0], 16'd0);

        // Temperature snapshot
        temp_pulse(16'h0190);
        cs_begin();
        spi_bits(8'hC1, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx2);
        cs_end();
        check_val("temp_h", {8'd0, rx}, 16'h0001);
        check_val("temp_l", {8'd0, rx2}, 16'h0090);

        // Write and read back PWR_MGMT_1
        cs_begin();
        spi_bits(8'h6B, 8, rx);
        spi_bits(8'h80, 8, rx);
        cs_end();
        check_val("wr_cnt_pwr", wr_cnt[15:0], 16'd1);
        check_val("wr_addr_pwr", {9'd0, last_wr_addr}, 16'h006B);
        check_val("wr_data_pwr", {8'd0, last_wr_data}, 16'h0080);
        read1(8'hEB, rx);
        check_val("pwr_rdback", {8'd0, rx}, 16'h0080);

        // Write to read-only WHO_AM_I is dropped
        cs_begin();
        spi_bits(8'h75, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        check_val("wr_cnt_ro", wr_cnt[15:0], 16'd1);
        read1(8'hF5, rx);
        check_val("who_after_wr", {8'd0, rx}, 16'h0071);

        // Burst write wrapping 0x7F -> 0x00, then burst read back
        cs_begin();
        spi_bits(8'h7F, 8, rx);
        spi_bits(8'hAA, 8, rx);
        check_val("wr_addr_7f", {9'd0, last_wr_addr}, 16'h007F);
        check_val("wr_data_7f", {8'd0, last_wr_data}, 16'h00AA);
        spi_bits(8'hBB, 8, rx);
        cs_end();
        check_val("wr_cnt_burst", wr_cnt[15:0], 16'd3);
        check_val("wr_addr_wrap", {9'd0, last_wr_addr}, 16'h0000);
        check_val("wr_data_wrap", {8'd0, last_wr_data}, 16'h00BB);
        cs_begin();
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx2);
        cs_end();
        check_val("rd_7f", {8'd0, rx}, 16'h00AA);
        check_val("rd_wrap", {8'd0, rx2}, 16'h00BB);

        // Partial byte aborted by CS_n rise
        wr_before = wr_cnt;
        cs_begin();
        spi_bits(8'h41, 8, rx);
        spi_bits(8'hFF, 5, rx);
        check_val("busy_partial", {15'd0, busy}, 16'h0001);
        cs_end();
        check_val("busy_after_abort", {15'd0, busy}, 16'h0000);
        check_val("wr_cnt_abort", wr_cnt[15:0], wr_before[15:0]);
        read1(8'hF5, rx);
        check_val("who_after_abort", {8'd0, rx}, 16'h0071);

        // Coherent burst while the holding register changes mid-frame
        cs_begin();
        spi_bits(8'hC1, 8, rx);
        spi_bits(8'h00, 8, rx);
        temp_pulse(16'h1234);
        spi_bits(8'h00, 8, rx2);
        cs_end();
        check_val("coh_h", {8'd0, rx}, 16'h0001);
        check_val("coh_l", {8'd0, rx2}, 16'h0090);
        cs_begin();
        spi_bits(8'hC1, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx2);
        cs_end();
        check_val("new_h", {8'd0, rx}, 16'h0012);
        check_val("new_l", {8'd0, rx2}, 16'h0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mpu_spi_responder.md
# mpu_spi_responder

Synthesizable SPI responder that emulates the MPU-9250 register interface, so the existing MPU SPI controllers can be exercised against real RTL and looped back on-board. It oversamples SCLK/CS_n/MOSI in the system clock domain and decodes the command byte (R/W + 7-bit address). It serves burst reads and writes from a 128×8 register file with auto-incrementing address. TEMP_OUT_H/L are fed from a local 16-bit source and snapshotted per transaction.

## Interface
- WHO_AM_I_VAL, 8'h71, reset/read-only value of register 0x75
- PWR_MGMT_1_RST, 8'h01, reset value of register 0x6B
- i_Clk  in  1  system clock; must be ≥ 8× SCLK frequency
- i_Rst  in  1  synchronous, active-high reset
- i_cs_n  in  1  SPI chip select, active low, asynchronous to i_Clk
- i_SPI_Clk  in  1  SPI clock, mode 3 (idle high), asynchronous
- i_SPI_MOSI  in  1  master-out data
- o_SPI_MISO  out  1  slave-out data
- o_miso_oe  out  1  MISO output enable (1 only while selected)
- i_temp_raw  in  16  temperature sample {H,L}
- i_temp_valid  in  1  single-cycle strobe: load i_temp_raw into holding reg
- o_wr_valid  out  1  single-cycle pulse per accepted write byte
- o_wr_addr  out  7  address of accepted write
- o_wr_data  out  8  data of accepted write
- o_busy  out  1  high while a transaction is in progress (state ≠ IDLE)

## Operation
- Input sync: 2-flop synchronizers on i_cs_n, i_SPI_Clk, i_SPI_MOSI; third flop on SCLK for edge detect (rise = sampled 0→1, fall = 1→0).
- Mode 3: MOSI sampled on SCLK rise; MISO shifted on SCLK fall; MSB first.
- FSM states: IDLE, CMD, RD, WR.
  - IDLE → CMD on synced CS_n falling; clear bit counter, snapshot temp holding reg into TEMP_OUT_H (0x41) / TEMP_OUT_L (0x42).
  - CMD: shift 8 MOSI bits; on 8th rise latch addr = bits[6:0]; bit7=1 → RD, else → WR.
  - RD: on entry, load shift reg with reg[addr] and increment addr. Each SCLK fall drives the next MSB. After each 8th rise, load reg[addr] and increment addr.
  - WR: shift 8 bits; on 8th rise write reg[addr] (unless read-only), pulse o_wr_valid, then addr+1.
  - Any state → IDLE on synced CS_n high; a partial byte is discarded (no write, no pulse).
- Address increments modulo 128 (0x7F → 0x00).
- Read-only: 0x41, 0x42, 0x75; writes to them are dropped with no o_wr_valid.
- During CMD, MISO = 0. o_miso_oe = ~synced CS_n.
- Temp holding reg: loaded on i_temp_valid (reset 16'h0000). Registers 0x41/0x42 change only at CS_n fall, so a burst read is coherent.
- If i_temp_valid and CS_n fall occur in the same cycle, the snapshot takes the old holding value.
- Register file reset: all 0x00 except 0x6B = PWR_MGMT_1_RST and 0x75 = WHO_AM_I_VAL.

## Timing
- Outputs on reset: o_SPI_MISO=0, o_miso_oe=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, FSM=IDLE.
- Reset mid-transaction returns to IDLE and restores register defaults. The rest of that SPI frame is ignored until the next CS_n fall.
- Edge-detect latency: 3 i_Clk cycles from pin edge to internal strobe.
- The RD load completes within 1 cycle of the 8th-rise strobe, ahead of the next SCLK fall (≥4 i_Clk later).
- MISO changes ≤ 4 i_Clk after the SCLK fall pin edge.
- o_wr_valid rises 1 cycle after the 8th-rise strobe of a data byte, for exactly 1 cycle.
- o_busy rises 1 cycle after the synced CS_n fall and drops 1 cycle after the synced CS_n rise.

## Test plan
- Reset, then read 0xF5 + 1 dummy byte → MISO byte1 = 0x71; read 0xEB → 0x01; o_wr_valid never pulses.
- i_temp_valid with 0x0190, then CS_n low, send 0xC1 + 2 dummies → MISO 0x01, 0x90 (matches controller expectation of 400 decimal).
- Write 0x6B then 0x80 → one o_wr_valid, addr 0x6B, data 0x80; read 0xEB back → 0x80. Write 0x75 then 0x00 → no pulse; WHO_AM_I still reads 0x71.
- Burst write 0x7F, 0xAA, 0xBB → writes at 0x7F then 0x00; read 0xFF + 2 dummies → 0xAA, 0xBB (wrap).
- Send 0x41 then 5 bits, raise CS_n → no write, o_busy drops, next transaction decodes normally.
- Pulse i_temp_valid 0x1234 between the two read bytes of a 0xC1 burst (snapshot 0x0190) → 0x01, 0x90. The next transaction returns 0x12, 0x34.
